// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StDrain
  } ifu_state_e;

  localparam logic [31:0] NopInst = 32'h0000_0013;
  localparam int unsigned PcStep  = 4;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush and occupancy count; used both as the
// in-flight pc queue and as the fetched-instruction buffer.
module ifu_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifu_pipe.sv
// Instruction fetch unit: issues sequential fetches, pairs in-order responses
// with their pc, buffers them for decode and discards responses after redirects.
module ifu_pipe
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned BufW = ADDR_WIDTH + DATA_WIDTH;

  ifu_state_e            state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [CntW-1:0]       drop_cnt_q;

  logic [CntW-1:0]       pcq_cnt, buf_cnt;
  logic [ADDR_WIDTH-1:0] pcq_head;
  logic [BufW-1:0]       buf_head;
  logic [SumW-1:0]       inflight, occupancy, drop_next;
  logic                  req_fire, rsp_take, rsp_drop, rsp_keep, out_fire;

  // Requests awaiting a response: those still owed to decode plus those to discard.
  assign inflight  = SumW'(pcq_cnt) + SumW'(drop_cnt_q);
  assign occupancy = inflight + SumW'(buf_cnt);

  assign req_valid = (state_q == StFetch) && (occupancy < SumW'(DEPTH));
  assign req_addr  = fetch_pc_q;
  assign req_fire  = req_valid && req_ready;

  assign rsp_take  = rsp_valid && (inflight != '0);
  assign rsp_drop  = rsp_take && (drop_cnt_q != '0);
  assign rsp_keep  = rsp_take && (drop_cnt_q == '0);

  assign out_valid = (buf_cnt != '0);
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = out_valid ? buf_head[BufW-1:DATA_WIDTH] : RESET_PC;
  assign out_inst  = out_valid ? buf_head[DATA_WIDTH-1:0] : DATA_WIDTH'(NopInst);

  assign drop_next = inflight + SumW'(req_fire) - SumW'(rsp_take);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      drop_cnt_q <= CntW'(drop_next);
      state_q    <= (drop_next != '0) ? StDrain : StFetch;
    end else begin
      if (req_fire) fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(PcStep);
      if (rsp_drop) drop_cnt_q <= drop_cnt_q - CntW'(1);
      unique case (state_q)
        StBoot:  state_q <= StFetch;
        StDrain: if (rsp_drop && (drop_cnt_q == CntW'(1))) state_q <= StFetch;
        default: ;
      endcase
    end
  end

  ifu_fifo #(
    .Width(ADDR_WIDTH),
    .Depth(DEPTH)
  ) u_pc_queue (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (req_fire),
    .wdata_i(fetch_pc_q),
    .pop_i  (rsp_keep),
    .flush_i(redirect_valid),
    .rdata_o(pcq_head),
    .count_o(pcq_cnt)
  );

  ifu_fifo #(
    .Width(BufW),
    .Depth(DEPTH)
  ) u_inst_buf (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (rsp_keep),
    .wdata_i({pcq_head, rsp_data}),
    .pop_i  (out_fire),
    .flush_i(redirect_valid),
    .rdata_o(buf_head),
    .count_o(buf_cnt)
  );

endmodule

// File: tb/tb_ifu_pipe.sv
// Bench for ifu_pipe: queue-based reference model checked every cycle, plus
// directed scenarios with literal expected fetch/decode addresses.
module tb_ifu_pipe;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam int          Depth   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, rsp_valid, out_valid, out_ready, redirect_valid;
  logic [31:0] req_addr, rsp_data, out_inst, out_pc, redirect_pc;

  ifu_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory side: answers every accepted request after rsp_lat cycles, in order.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];
  int    rsp_lat = 1;
  bit    rsp_en  = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rsp_en && pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
  end

  // Reference model: inflight requests (with discard flag) and decode buffer.
  typedef struct {
    logic [31:0] pc;
    bit          keep;
  } mi_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } mb_t;
  mi_t         m_inf[$];
  mb_t         m_buf[$];
  logic [31:0] m_pc;
  bit          m_boot;

  function automatic bit m_req_valid();
    bit drain = 1'b0;
    foreach (m_inf[i]) if (!m_inf[i].keep) drain = 1'b1;
    return !m_boot && !drain && (m_inf.size() + m_buf.size() < Depth);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_inf.delete();
      m_buf.delete();
      m_pc   = ResetPc;
      m_boot = 1'b1;
    end else begin
      bit  fire;
      mi_t e;
      mb_t b;
      fire = m_req_valid() && req_ready;
      if (m_buf.size() > 0 && out_ready) void'(m_buf.pop_front());
      if (rsp_valid && m_inf.size() > 0) begin
        e = m_inf.pop_front();
        if (e.keep) begin
          b.pc   = e.pc;
          b.inst = rsp_data;
          m_buf.push_back(b);
        end
      end
      if (fire) begin
        e.pc   = m_pc;
        e.keep = 1'b1;
        m_inf.push_back(e);
      end
      if (redirect_valid) begin
        m_buf.delete();
        foreach (m_inf[i]) m_inf[i].keep = 1'b0;
        m_pc = redirect_pc;
      end else if (fire) begin
        m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
  end

  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] pop_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, ResetPc);
      chk("rst_out_inst", out_inst, 32'h0000_0013);
    end else begin
      chk("req_valid", 32'(req_valid), 32'(m_req_valid()));
      if (m_req_valid()) chk("req_addr", req_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        chk("out_pc", out_pc, m_buf[0].pc);
        chk("out_inst", out_inst, m_buf[0].inst);
      end
    end
    if (req_valid && req_ready) begin
      pend_t p;
      p.addr = req_addr;
      p.due  = cyc + rsp_lat;
      pend.push_back(p);
      fire_log.push_back(req_addr);
    end
    if (out_valid && out_ready) begin
      pop_log.push_back(out_pc);
      pop_cyc.push_back(32'(cyc));
    end
  end

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic log_clear();
    fire_log.delete();
    pop_log.delete();
    pop_cyc.delete();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    req_ready      = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rsp_valid      = 1'b0;
    rsp_data       = 32'h0;

    // Sequential streaming after reset
    tick(3);
    rst = 1'b1;
    log_clear();
    tick(10);
    chk("seq_fire0", at(fire_log, 0), 32'h8000_0000);
    chk("seq_fire1", at(fire_log, 1), 32'h8000_0004);
    chk("seq_fire2", at(fire_log, 2), 32'h8000_0008);
    chk("seq_pop0", at(pop_log, 0), 32'h8000_0000);
    chk("seq_pop1", at(pop_log, 1), 32'h8000_0004);
    chk("seq_pop2", at(pop_log, 2), 32'h8000_0008);
    chk("seq_pop_rate", at(pop_cyc, 1) - at(pop_cyc, 0), 32'd1);

    // Decode stall: occupancy limit
    rst       = 1'b0;
    out_ready = 1'b0;
    tick(2);
    rst = 1'b1;
    log_clear();
    tick(10);
    chk("stall_fire_count", 32'(fire_log.size()), 32'd4);
    chk("stall_req_valid", 32'(req_valid), 32'd0);
    out_ready = 1'b1;
    tick(4);
    chk("stall_resume", 32'(fire_log.size() > 4), 32'd1);

    // Redirect with two requests outstanding
    rst       = 1'b0;
    req_ready = 1'b0;
    rsp_en    = 1'b0;
    tick(2);
    rst = 1'b1;
    log_clear();
    tick(1);
    req_ready = 1'b1;
    tick(2);
    req_ready = 1'b0;
    chk("two_inflight_fires", 32'(fire_log.size()), 32'd2);
    redirect(32'h8000_0100);
    chk("drain_req_valid", 32'(req_valid), 32'd0);
    log_clear();
    rsp_en    = 1'b1;
    req_ready = 1'b1;
    tick(10);
    chk("redir_fire0", at(fire_log, 0), 32'h8000_0100);
    chk("redir_fire1", at(fire_log, 1), 32'h8000_0104);
    chk("redir_pop0", at(pop_log, 0), 32'h8000_0100);

    // Redirect coinciding with a request handshake
    log_clear();
    redirect(32'h8000_0200);
    chk("redir_cycle_fire", 32'(fire_log.size()), 32'd1);
    log_clear();
    tick(8);
    chk("same_cyc_fire0", at(fire_log, 0), 32'h8000_0200);
    chk("same_cyc_pop0", at(pop_log, 0), 32'h8000_0200);

    // Second redirect while draining
    tick(2);
    redirect(32'h8000_0300);
    redirect(32'h8000_0380);
    log_clear();
    tick(8);
    chk("drain_redir_fire0", at(fire_log, 0), 32'h8000_0380);
    chk("drain_redir_pop0", at(pop_log, 0), 32'h8000_0380);

    // Address wrap
    tick(2);
    redirect(32'hFFFF_FFFC);
    log_clear();
    tick(8);
    chk("wrap_fire0", at(fire_log, 0), 32'hFFFF_FFFC);
    chk("wrap_fire1", at(fire_log, 1), 32'h0000_0000);
    chk("wrap_pop0", at(pop_log, 0), 32'hFFFF_FFFC);
    chk("wrap_pop1", at(pop_log, 1), 32'h0000_0000);

    // Asynchronous reset mid-stream with several requests outstanding
    rsp_lat = 3;
    tick(6);
    rst = 1'b0;
    #1;
    chk("async_req_valid", 32'(req_valid), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_pc", out_pc, 32'h8000_0000);
    chk("async_out_inst", out_inst, 32'h0000_0013);
    rsp_lat = 1;
    tick(2);
    log_clear();
    rst = 1'b1;
    tick(8);
    chk("restart_fire0", at(fire_log, 0), 32'h8000_0000);
    chk("restart_fire1", at(fire_log, 1), 32'h8000_0004);
    chk("restart_pop0", at(pop_log, 0), 32'h8000_0000);

    // Redirect during boot replaces the reset pc
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    log_clear();
    redirect(32'h8000_0400);
    tick(6);
    chk("boot_redir_fire0", at(fire_log, 0), 32'h8000_0400);
    chk("boot_redir_pop0", at(pop_log, 0), 32'h8000_0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_pipe.md
IFU_PIPE -- requirements
Module: ifu_pipe

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning fetch address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address.
REQ-004 The block SHALL have parameter DEPTH, default 4 (power of two, >=2), meaning maximum inflight requests plus buffered instructions.
REQ-005 Ports SHALL be: clk  in  1  single clock, all state on rising edge.
REQ-006 Ports SHALL be: rst  in  1  reset, asynchronous, active-low.
REQ-007 Ports SHALL be: req_valid  out  1  fetch request valid; req_ready  in  1  memory accepts; req_addr  out  ADDR_WIDTH  fetch address.
REQ-008 Ports SHALL be: rsp_valid  in  1  instruction returned, in order, no backpressure; rsp_data  in  DATA_WIDTH  instruction word.
REQ-009 Ports SHALL be: out_valid  out  1, out_ready  in  1, out_inst  out  DATA_WIDTH, out_pc  out  ADDR_WIDTH, forming the decode-side handshake.
REQ-010 Ports SHALL be: redirect_valid  in  1  branch/jump redirect; redirect_pc  in  ADDR_WIDTH  new fetch address.

Function
REQ-011 The block SHALL implement states BOOT, FETCH and DRAIN.
REQ-012 BOOT: entered on reset; req_valid=0; moves to FETCH after exactly one clk edge.
REQ-013 FETCH: req_valid=1 iff inflight+buffered < DEPTH; req_addr=fetch_pc; req_valid depends only on registered state.
REQ-014 Request handshake (req_valid&&req_ready) SHALL advance fetch_pc by 4, modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0000_0000), and push the request pc into the pc queue.
REQ-015 Each rsp_valid not being dropped SHALL write {pc-queue head, rsp_data} into the instruction buffer in the same edge.
REQ-016 out_valid SHALL equal buffer-not-empty; out_inst/out_pc SHALL show the buffer head; pop on out_valid&&out_ready.
REQ-017 Simultaneous response write and pop SHALL be supported with count unchanged; empty buffer: response visible on out_* next cycle (1-cycle latency).
REQ-018 redirect_valid SHALL, on that edge: load fetch_pc<=redirect_pc, clear the buffer and pc queue, set drop_cnt to the inflight count after that cycle's request/response, and go to DRAIN if drop_cnt>0, else FETCH.
REQ-019 A request handshaking in the redirect cycle SHALL count as inflight and be dropped.
REQ-020 DRAIN: req_valid=0; each rsp_valid decrements drop_cnt and is discarded; at drop_cnt reaching 0, go to FETCH.
REQ-021 Redirect in DRAIN SHALL reload fetch_pc and keep dropping all inflight responses.
REQ-022 Redirect in BOOT SHALL replace RESET_PC as first fetch address.
REQ-023 rsp_valid with zero inflight SHALL be ignored.

Reset
REQ-024 While rst=0: state=BOOT, fetch_pc=RESET_PC, inflight=0, drop_cnt=0, buffer empty, req_valid=0, out_valid=0, out_inst=32'h0000_0013 (NOP), out_pc=RESET_PC.
REQ-025 Reset asserted mid-operation SHALL discard all inflight and buffered state; responses arriving after release with zero inflight are ignored per REQ-023.

Structure
REQ-026 Package ifu_pkg SHALL hold the state enum, the NOP constant 32'h0000_0013 and the PC step constant 4.
REQ-027 A sub-module ifu_fifo (parametrised width/depth, push/pop/flush, count) SHALL implement both the pc queue and the instruction buffer.

Verification
REQ-028 Reset release, req_ready=1, rsp one cycle after request, out_ready=1 -> req_addr 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pc matching in order, one per cycle.
REQ-029 out_ready=0 for 10 cycles -> exactly DEPTH (4) requests issued, then req_valid=0; after out_ready=1, issuing resumes.
REQ-030 Redirect to 0x8000_0100 with 2 inflight -> the next 2 responses dropped, next req_addr 0x8000_0100, no stale out_pc.
REQ-031 Redirect in the same cycle as a request handshake -> that response dropped; first out_pc = redirect_pc.
REQ-032 Redirect to 0xFFFF_FFFC -> req_addr 0xFFFF_FFFC then 0x0000_0000.
REQ-033 rst=0 mid-stream with 3 inflight -> outputs return to reset values asynchronously; fetch restarts at 0x8000_0000 after BOOT.
